// File: rtl/irq_controller.sv
// Four-line edge-triggered interrupt controller with a mask register and a
// REQ/ack/SERVICE/done handshake; priority resolution is done by an external encoder.
module irq_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       mask_wr,
    input  logic [3:0] mask_din,
    input  logic       gie,
    output logic [3:0] enc_in,
    output logic       enc_en,
    input  logic [1:0] enc_out,
    input  logic       enc_valid,
    output logic       int_req,
    output logic [1:0] int_id,
    input  logic       int_ack,
    input  logic       int_done,
    output logic [3:0] mask,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] irq_prev;
    logic [3:0] pending;
    logic [3:0] pending_set;
    logic [3:0] pending_clr;
    logic       id_load;

    assign pending_set = irq & ~irq_prev;
    assign enc_in      = pending & mask;
    assign enc_en      = gie & (state == IDLE) & ~reset;
    assign int_req     = (state == REQ) & ~reset;
    assign busy        = (state == SERVICE) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        id_load     = 1'b0;
        pending_clr = 4'b0000;
        case (state)
            IDLE: begin
                if (enc_en && enc_valid && (enc_in != 4'b0000)) begin
                    id_load    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over a simultaneous loss of gie.
                if (int_ack) begin
                    pending_clr = 4'b0001 << int_id;
                    state_next  = SERVICE;
                end else if (!gie) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new edge in the same cycle as the clear leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= 4'b0000;
            pending  <= 4'b0000;
        end else begin
            irq_prev <= irq;
            pending  <= (pending & ~pending_clr) | pending_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask   <= 4'b0000;
            int_id <= 2'b00;
        end else begin
            if (mask_wr) begin
                mask <= mask_din;
            end
            if (id_load) begin
                int_id <= enc_out;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller; models the downstream priority encoder
// (highest index wins) and checks each handshake scenario with hand-computed values.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_wr;
    logic [3:0] mask_din;
    logic       gie;
    logic [3:0] enc_in;
    logic       enc_en;
    logic [1:0] enc_out;
    logic       enc_valid;
    logic       int_req;
    logic [1:0] int_id;
    logic       int_ack;
    logic       int_done;
    logic [3:0] mask;
    logic       busy;

    int errors = 0;
    int checks = 0;

    irq_controller dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_wr(mask_wr), .mask_din(mask_din),
        .gie(gie), .enc_in(enc_in), .enc_en(enc_en), .enc_out(enc_out),
        .enc_valid(enc_valid), .int_req(int_req), .int_id(int_id), .int_ack(int_ack),
        .int_done(int_done), .mask(mask), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment model of the priority encoder: highest set index wins.
    always_comb begin
        enc_out   = 2'b00;
        enc_valid = enc_en & (enc_in != 4'b0000);
        if (enc_in[3])      enc_out = 2'b11;
        else if (enc_in[2]) enc_out = 2'b10;
        else if (enc_in[1]) enc_out = 2'b01;
        else                enc_out = 2'b00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq = 4'b0000; mask_wr = 1'b0; mask_din = 4'b0000;
        gie = 1'b1; int_ack = 1'b0; int_done = 1'b0;
        tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_int_req got=%b exp=0", int_req); end
        checks++; if (int_id !== 2'b00) begin errors++; $display("[TB] FAIL rst_int_id got=%b exp=00", int_id); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mask got=%b exp=0000", mask); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (enc_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_enc_en got=%b exp=0", enc_en); end
        checks++; if (enc_in !== 4'b0000) begin errors++; $display("[TB] FAIL rst_enc_in got=%b exp=0000", enc_in); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        mask_wr = 1'b1; mask_din = 4'b1111; tick(); mask_wr = 1'b0;
        checks++; if (mask !== 4'b1111) begin errors++; $display("[TB] FAIL t1_mask got=%b exp=1111", mask); end
        irq = 4'b0100; tick();
        checks++; if (enc_in !== 4'b0100) begin errors++; $display("[TB] FAIL t1_pending got=%b exp=0100", enc_in); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t1_req_early got=%b exp=0", int_req); end
        irq = 4'b0000; tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t1_req got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b10) begin errors++; $display("[TB] FAIL t1_id got=%b exp=10", int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy got=%b exp=1", busy); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t1_req_drop got=%b exp=0", int_req); end
        checks++; if (enc_in !== 4'b0000) begin errors++; $display("[TB] FAIL t1_clr got=%b exp=0000", enc_in); end
        int_done = 1'b1; tick(); int_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_done_busy got=%b exp=0", busy); end
        checks++; if (enc_en !== 1'b1) begin errors++; $display("[TB] FAIL t1_idle_en got=%b exp=1", enc_en); end
    endtask

    task automatic test_back_to_back();
        irq = 4'b1001; tick(); irq = 4'b0000; tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t2_req1 got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b11) begin errors++; $display("[TB] FAIL t2_id1 got=%b exp=11", int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        checks++; if (enc_in !== 4'b0001) begin errors++; $display("[TB] FAIL t2_left got=%b exp=0001", enc_in); end
        int_done = 1'b1; tick(); int_done = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t2_gap got=%b exp=0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t2_req2 got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b00) begin errors++; $display("[TB] FAIL t2_id2 got=%b exp=00", int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_done = 1'b1; tick(); int_done = 1'b0;
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_din = 4'b0000; tick(); mask_wr = 1'b0;
        irq = 4'b0010; tick(); irq = 4'b0000; tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t3_masked got=%b exp=0", int_req); end
        checks++; if (enc_in !== 4'b0000) begin errors++; $display("[TB] FAIL t3_enc_masked got=%b exp=0000", enc_in); end
        mask_wr = 1'b1; mask_din = 4'b0010; tick(); mask_wr = 1'b0;
        checks++; if (enc_in !== 4'b0010) begin errors++; $display("[TB] FAIL t3_unmask got=%b exp=0010", enc_in); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t3_req got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b01) begin errors++; $display("[TB] FAIL t3_id got=%b exp=01", int_id); end
        mask_wr = 1'b1; mask_din = 4'b0000; tick(); mask_wr = 1'b0;
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t3_req_hold got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b01) begin errors++; $display("[TB] FAIL t3_id_hold got=%b exp=01", int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_done = 1'b1; tick(); int_done = 1'b0;
        mask_wr = 1'b1; mask_din = 4'b1111; tick(); mask_wr = 1'b0;
        checks++; if (enc_in !== 4'b0000) begin errors++; $display("[TB] FAIL t3_cleared got=%b exp=0000", enc_in); end
    endtask

    task automatic test_gie_drop();
        irq = 4'b1000; tick(); irq = 4'b0000; tick();
        checks++; if (int_id !== 2'b11) begin errors++; $display("[TB] FAIL t4_id got=%b exp=11", int_id); end
        gie = 1'b0; tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t4_drop got=%b exp=0", int_req); end
        checks++; if (enc_in !== 4'b1000) begin errors++; $display("[TB] FAIL t4_kept got=%b exp=1000", enc_in); end
        checks++; if (enc_en !== 1'b0) begin errors++; $display("[TB] FAIL t4_en_off got=%b exp=0", enc_en); end
        gie = 1'b1; #1;
        checks++; if (enc_en !== 1'b1) begin errors++; $display("[TB] FAIL t4_en_on got=%b exp=1", enc_en); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t4_rereq got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b11) begin errors++; $display("[TB] FAIL t4_reid got=%b exp=11", int_id); end
        gie = 1'b0; int_ack = 1'b1; tick(); int_ack = 1'b0; gie = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t4_ack_wins got=%b exp=1", busy); end
        int_done = 1'b1; tick(); int_done = 1'b0;
    endtask

    task automatic test_set_clear();
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        checks++; if (int_id !== 2'b10) begin errors++; $display("[TB] FAIL t5_id got=%b exp=10", int_id); end
        irq = 4'b0100; int_ack = 1'b1; tick(); irq = 4'b0000; int_ack = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t5_busy got=%b exp=1", busy); end
        checks++; if (enc_in !== 4'b0100) begin errors++; $display("[TB] FAIL t5_set_wins got=%b exp=0100", enc_in); end
        int_done = 1'b1; tick(); int_done = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t5_gap got=%b exp=0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t5_rereq got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b10) begin errors++; $display("[TB] FAIL t5_reid got=%b exp=10", int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_done = 1'b1; tick(); int_done = 1'b0;
    endtask

    task automatic test_reset_service();
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t6_busy got=%b exp=1", busy); end
        reset = 1'b1; irq = 4'b0010; tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_busy got=%b exp=0", busy); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL t6_rst_mask got=%b exp=0000", mask); end
        checks++; if (int_id !== 2'b00) begin errors++; $display("[TB] FAIL t6_rst_id got=%b exp=00", int_id); end
        checks++; if (enc_en !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_en got=%b exp=0", enc_en); end
        gie = 1'b0; reset = 1'b0; tick();
        checks++; if (enc_in !== 4'b0000) begin errors++; $display("[TB] FAIL t6_post_masked got=%b exp=0000", enc_in); end
        mask_wr = 1'b1; mask_din = 4'b1111; tick(); mask_wr = 1'b0;
        checks++; if (enc_in !== 4'b0010) begin errors++; $display("[TB] FAIL t6_post_edge got=%b exp=0010", enc_in); end
        int_ack = 1'b1; int_done = 1'b1; tick(); int_ack = 1'b0; int_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_stray_busy got=%b exp=0", busy); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL t6_stray_req got=%b exp=0", int_req); end
        checks++; if (enc_in !== 4'b0010) begin errors++; $display("[TB] FAIL t6_stray_pend got=%b exp=0010", enc_in); end
        gie = 1'b1; tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL t6_req got=%b exp=1", int_req); end
        checks++; if (int_id !== 2'b01) begin errors++; $display("[TB] FAIL t6_id got=%b exp=01", int_id); end
        irq = 4'b0000; int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_done = 1'b1; tick(); int_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_gie_drop();
        test_set_clear();
        test_reset_service();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
